sim_ctrl_responder: RTL and testbench

Memory-mapped simulation-control responder on the core's data bus. It lets test programs report completion, pass/fail and a result code by store instructions, so the bench no longer has to peek at register-file contents. It also provides a byte console FIFO that the bench drains, a free-running cycle counter and a watchdog timeout. It is the bus-side responder that the bench observes through `done`, `pass`, `code` and `timeout`.

---
 rtl/sim_ctrl_responder.sv | 150 +++++++++++++++
 tb/tb_sim_ctrl_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sim_ctrl_responder.sv
`default_nettype none
// sim_ctrl_responder: bus-mapped test status/result registers, console byte FIFO,
// free-running cycle counter and watchdog used by test programs to report to the bench.
module sim_ctrl_responder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              done,
  output logic              pass,
  output logic [31:0]       code,
  output logic              timeout,
  output logic              con_valid,
  output logic [7:0]        con_data,
  input  logic              con_ready
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  A_STATUS  = 3'd0;
  localparam logic [2:0]  A_CODE    = 3'd1;
  localparam logic [2:0]  A_CONSOLE = 3'd2;
  localparam logic [2:0]  A_CYCLES  = 3'd3;
  localparam logic [2:0]  A_TMO     = 3'd4;
  localparam logic [31:0] TMO_VAL   = 32'(TIMEOUT_CYCLES);

  logic        ovf;
  logic [31:0] cycles;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wptr, rptr, wptr_nxt, rptr_nxt, count;

  logic        accept, wr;
  logic [2:0]  idx;
  logic        full, pop, push_req, push_ok, ovf_set;
  logic        done_set, code_we, tmo_set;
  logic [7:0]  head_nxt;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[ADDR_W-1:5], req_addr[1:0]};

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign wr        = accept && req_we;
  assign idx       = req_addr[4:2];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wptr - rptr;
  assign con_valid = (wptr != rptr);
  assign full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign pop       = con_valid && con_ready;
  assign push_req  = wr && (idx == A_CONSOLE) && req_wstrb[0];
  assign push_ok   = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign rptr_nxt  = rptr + {{PW{1'b0}}, pop};
  assign wptr_nxt  = wptr + {{PW{1'b0}}, push_ok};

  assign done_set  = wr && (idx == A_STATUS) && req_wstrb[0] && req_wdata[0] && !done;
  assign code_we   = wr && (idx == A_CODE) && !done;
  // A STATUS write that lands on the expiry edge takes priority over the watchdog.
  assign tmo_set   = !done && !done_set && (cycles != 32'hFFFF_FFFF) &&
                     ((cycles + 32'd1) == TMO_VAL);

  // Next registered head: the byte being written now if it becomes the head.
  always_comb begin
    head_nxt = 8'h00;
    if (wptr_nxt != rptr_nxt) begin
      if (push_ok && (rptr_nxt == wptr))
        head_nxt = req_wdata[7:0];
      else
        head_nxt = mem[rptr_nxt[PW-1:0]];
    end
  end

  always_comb begin
    rd_data = 32'h0;
    rd_err  = 1'b0;
    case (idx)
      A_STATUS:  rd_data = {29'b0, ovf, pass, done};
      A_CODE:    rd_data = code;
      A_CONSOLE: rd_data = 32'(count);
      A_CYCLES:  rd_data = cycles;
      A_TMO:     rd_data = TMO_VAL;
      default:   rd_err  = 1'b1;
    endcase
    if (req_we) rd_data = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[PW-1:0]] <= req_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      code      <= 32'h0;
      timeout   <= 1'b0;
      ovf       <= 1'b0;
      cycles    <= 32'h0;
      wptr      <= '0;
      rptr      <= '0;
      con_data  <= 8'h00;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rd_data;
        rsp_err   <= rd_err;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (done_set) begin
        done <= 1'b1;
        pass <= req_wdata[1];
      end

      if (code_we) begin
        for (int b = 0; b < 4; b++) begin
          if (req_wstrb[b]) code[8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end

      if (cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
      if (tmo_set) timeout <= 1'b1;
      if (ovf_set) ovf <= 1'b1;

      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      con_data <= head_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_ctrl_responder.sv
`default_nettype none
// tb_sim_ctrl_responder: directed checks of the simulation-control responder.
module tb_sim_ctrl_responder;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        done, pass, timeout;
  logic [31:0] code;
  logic        con_valid, con_ready;
  logic [7:0]  con_data;

  int total = 0;
  int bad   = 0;
  int edges;

  sim_ctrl_responder #(
    .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(20),
    .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .done(done), .pass(pass), .code(code),
    .timeout(timeout), .con_valid(con_valid), .con_data(con_data),
    .con_ready(con_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen since reset was released.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rd, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    @(posedge clk);
    #1;
    chk("rsp_valid_after_accept", {31'b0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    err = rsp_err;
    req_valid = 1'b0; req_we = 1'b0; req_wstrb = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; con_ready = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  logic [7:0]  exp_bytes [8];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b1; con_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("rst_done",      {31'b0, done}, 32'd0);
    chk("rst_pass",      {31'b0, pass}, 32'd0);
    chk("rst_code",      code, 32'd0);
    chk("rst_timeout",   {31'b0, timeout}, 32'd0);
    chk("rst_con_valid", {31'b0, con_valid}, 32'd0);
    chk("rst_con_data",  {24'b0, con_data}, 32'd0);
    rst = 1'b0;

    // First read after reset samples CYCLES after exactly one edge
    bus(1'b0, 32'h0C, 32'h0, 4'h0, rd, err);
    chk("cycles_first", rd, 32'd1);
    chk("cycles_err", {31'b0, err}, 32'd0);

    // Watchdog expires when CYCLES reaches 20
    begin
      int g = 0;
      while (edges != 19 && g < 200) begin @(negedge clk); g++; end
    end
    chk("wdog_wait_19", 32'(edges), 32'd19);
    chk("timeout_at_19", {31'b0, timeout}, 32'd0);
    @(negedge clk);
    chk("timeout_at_20", {31'b0, timeout}, 32'd1);
    bus(1'b0, 32'h10, 32'h0, 4'h0, rd, err);
    chk("tmo_read", rd, 32'd20);

    // STATUS still sets done after a timeout; later writes ignored
    bus(1'b1, 32'h00, 32'h3, 4'hF, rd, err);
    chk("status_done", {31'b0, done}, 32'd1);
    chk("status_pass", {31'b0, pass}, 32'd1);
    chk("status_write_rdata", rd, 32'd0);
    bus(1'b0, 32'h00, 32'h0, 4'h0, rd, err);
    chk("status_read", rd, 32'h3);
    bus(1'b1, 32'h00, 32'h1, 4'hF, rd, err);
    chk("status_pass_sticky", {31'b0, pass}, 32'd1);
    bus(1'b1, 32'h04, 32'h0000FFFF, 4'hF, rd, err);
    chk("code_after_done", code, 32'd0);
    chk("timeout_sticky", {31'b0, timeout}, 32'd1);

    // CODE byte strobes, then fail verdict freezes CODE
    do_reset();
    bus(1'b1, 32'h04, 32'hDEADBEEF, 4'h3, rd, err);
    chk("code_strb", code, 32'h0000BEEF);
    bus(1'b1, 32'h00, 32'h1, 4'hF, rd, err);
    chk("fail_done", {31'b0, done}, 32'd1);
    chk("fail_pass", {31'b0, pass}, 32'd0);
    bus(1'b1, 32'h04, 32'h12345678, 4'hF, rd, err);
    chk("code_frozen", code, 32'h0000BEEF);

    // Console overflow: nine pushes into an 8-deep FIFO
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus(1'b1, 32'h08, 32'h41 + i, 4'h1, rd, err);
      if (i == 0) begin
        chk("con_valid_first", {31'b0, con_valid}, 32'd1);
        chk("con_data_first", {24'b0, con_data}, 32'h41);
      end
    end
    bus(1'b0, 32'h08, 32'h0, 4'h0, rd, err);
    chk("con_count_full", rd, 32'd8);
    bus(1'b0, 32'h00, 32'h0, 4'h0, rd, err);
    chk("status_ovf", rd, 32'h4);
    @(negedge clk);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_ovf", {24'b0, con_data}, 32'h41 + i);
      @(negedge clk);
    end
    chk("drained_empty", {31'b0, con_valid}, 32'd0);
    con_ready = 1'b0;

    // Full FIFO: push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) bus(1'b1, 32'h08, 32'h30 + i, 4'h1, rd, err);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'h5A; req_wstrb = 4'h1;
    con_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_wstrb = 4'h0; con_ready = 1'b0;
    chk("pushpop_head", {24'b0, con_data}, 32'h31);
    bus(1'b0, 32'h08, 32'h0, 4'h0, rd, err);
    chk("pushpop_count", rd, 32'd8);
    bus(1'b0, 32'h00, 32'h0, 4'h0, rd, err);
    chk("pushpop_no_ovf", rd, 32'h0);
    exp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h5A};
    @(negedge clk);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_pushpop", {24'b0, con_data}, {24'b0, exp_bytes[i]});
      @(negedge clk);
    end
    chk("pushpop_empty", {31'b0, con_valid}, 32'd0);
    con_ready = 1'b0;

    // Response back-pressure
    rsp_ready = 1'b0;
    bus(1'b0, 32'h10, 32'h0, 4'h0, rd, err);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'd20);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_released", {31'b0, rsp_valid}, 32'd0);

    // Unmapped and read-only accesses
    bus(1'b0, 32'h1C, 32'h0, 4'h0, rd, err);
    chk("unmapped_rd_err", {31'b0, err}, 32'd1);
    chk("unmapped_rd_data", rd, 32'd0);
    bus(1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, rd, err);
    chk("unmapped_wr_err", {31'b0, err}, 32'd1);
    bus(1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, rd, err);
    chk("ro_wr_err", {31'b0, err}, 32'd0);

    // Reset in the middle of a stalled response
    rsp_ready = 1'b0;
    bus(1'b0, 32'h00, 32'h0, 4'h0, rd, err);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
